// File: rtl/hop_sel_kernel.sv
// hop_sel_kernel: basic and AFH-adapted hop selection kernel.
// Runs once per slot. start_p captures the hopping control word. The kernel then
// walks ADD -> PERM -> SUM -> CHECK. In basic mode, or when the basic channel is
// marked used in the AFH map, it goes straight to DONE. Otherwise it reduces the
// AFH sum mod N in MODN, one subtraction per cycle, and then scans the used-channel
// map in register-bank order in SCAN. Each run ends with a one-cycle chan_vld_p pulse.
module hop_sel_kernel #(
  parameter int NCH    = 79,
  parameter int MAXSUB = 13
) (
  input  logic           clk_6M,
  input  logic           rstz,
  input  logic           start_p,
  input  logic [4:0]     X,
  input  logic           Y1,
  input  logic [5:0]     Y2,
  input  logic [4:0]     A,
  input  logic [3:0]     B,
  input  logic [4:0]     C,
  input  logic [8:0]     D,
  input  logic [6:0]     E,
  input  logic [6:0]     F,
  input  logic [6:0]     Fprime,
  input  logic           regi_AFH_mode,
  input  logic [6:0]     regi_AFH_N,
  input  logic [NCH-1:0] regi_AFH_map,
  output logic [6:0]     chan_idx,
  output logic           chan_vld_p,
  output logic           busy,
  output logic           map_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_PERM, S_SUM, S_CHECK, S_MODN, S_SCAN, S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Captured control word
  logic [4:0] x_reg, a_reg, c_reg;
  logic       y1_reg, afh_mode_reg;
  logic [5:0] y2_reg;
  logic [3:0] b_reg;
  logic [8:0] d_reg;
  logic [6:0] e_reg, f_reg, fp_reg, afh_n_reg;

  // Pipeline and iteration state
  logic [4:0] z_reg, zp_reg;
  logic [6:0] ch_basic_reg;
  logic [8:0] sn_reg, sn_next;
  logic [3:0] sub_cnt_reg, sub_cnt_next;
  logic [6:0] idx_reg, idx_next;
  logic [6:0] scan_k_reg, scan_k_next;
  logic [6:0] scan_cnt_reg, scan_cnt_next;
  logic [6:0] res_ch_reg, res_ch_next;
  logic       map_err_reg, map_err_next;
  logic [6:0] chan_idx_reg;
  logic       chan_vld_reg;

  // Register bank order: even channels first, then odd channels
  function automatic logic [6:0] bank_ch(input logic [6:0] k);
    logic [6:0] hi;
    hi = k - 7'd40;
    if (k < 7'd40) return {k[5:0], 1'b0};
    else           return {hi[5:0], 1'b1};
  endfunction

  // Conditional exchange of two bits of the 5-bit word (one butterfly)
  function automatic logic [4:0] bfly(input logic [4:0] v, input logic en,
                                      input logic [2:0] i, input logic [2:0] j);
    logic [4:0] t;
    t = v;
    if (en) begin
      t[i] = v[j];
      t[j] = v[i];
    end
    return t;
  endfunction

  // Seven butterfly stages, applied from P13 down to P0
  function automatic logic [4:0] permute(input logic [4:0] z, input logic [13:0] p);
    logic [4:0] t;
    t = z;
    t = bfly(t, p[13], 3'd1, 3'd2);  t = bfly(t, p[12], 3'd0, 3'd3);
    t = bfly(t, p[11], 3'd1, 3'd3);  t = bfly(t, p[10], 3'd2, 3'd4);
    t = bfly(t, p[9],  3'd0, 3'd3);  t = bfly(t, p[8],  3'd1, 3'd4);
    t = bfly(t, p[7],  3'd3, 3'd4);  t = bfly(t, p[6],  3'd0, 3'd2);
    t = bfly(t, p[5],  3'd1, 3'd3);  t = bfly(t, p[4],  3'd0, 3'd4);
    t = bfly(t, p[3],  3'd3, 3'd4);  t = bfly(t, p[2],  3'd1, 3'd2);
    t = bfly(t, p[1],  3'd2, 3'd3);  t = bfly(t, p[0],  3'd0, 3'd1);
    return t;
  endfunction

  // Combinational datapath pieces
  logic [4:0]  z_add;
  logic [4:0]  z_c;
  logic [13:0] perm_p;
  logic [8:0]  s_sum, sn_sum, m1, m2;
  logic [6:0]  k_c, ch_c;
  logic [8:0]  n_ext, sn_sub;
  logic        n_bad;
  logic [6:0]  scan_ch;
  logic        scan_used;

  assign z_add     = x_reg + a_reg;
  assign z_c       = {z_add[4], z_add[3:0] ^ b_reg};
  assign perm_p    = {c_reg ^ {5{y1_reg}}, d_reg};
  assign s_sum     = 9'(zp_reg) + 9'(e_reg) + 9'(f_reg)  + 9'(y2_reg);
  assign sn_sum    = 9'(zp_reg) + 9'(e_reg) + 9'(fp_reg) + 9'(y2_reg);
  // Sum is at most 268, so three conditional subtractions of 79 reach the residue
  assign m1        = (s_sum >= 9'd79) ? s_sum - 9'd79 : s_sum;
  assign m2        = (m1    >= 9'd79) ? m1    - 9'd79 : m1;
  assign k_c       = (m2    >= 9'd79) ? 7'(m2 - 9'd79) : 7'(m2);
  assign ch_c      = bank_ch(k_c);
  assign n_ext     = 9'(afh_n_reg);
  assign sn_sub    = sn_reg - n_ext;
  assign n_bad     = (afh_n_reg < 7'd20) || (afh_n_reg > 7'(NCH));
  assign scan_ch   = bank_ch(scan_k_reg);
  assign scan_used = regi_AFH_map[scan_ch];

  // State register
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic plus the iterative mod-N and scan bookkeeping
  always_comb begin
    state_next    = state_reg;
    sn_next       = sn_reg;
    sub_cnt_next  = sub_cnt_reg;
    idx_next      = idx_reg;
    scan_k_next   = scan_k_reg;
    scan_cnt_next = scan_cnt_reg;
    res_ch_next   = res_ch_reg;
    map_err_next  = map_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_p) begin
          state_next   = S_ADD;
          map_err_next = 1'b0;
        end
      end
      S_ADD:  state_next = S_PERM;
      S_PERM: state_next = S_SUM;
      S_SUM: begin
        state_next = S_CHECK;
        sn_next    = sn_sum;
      end
      S_CHECK: begin
        sub_cnt_next  = '0;
        scan_k_next   = '0;
        scan_cnt_next = '0;
        res_ch_next   = ch_basic_reg;
        if (!afh_mode_reg || regi_AFH_map[ch_basic_reg]) state_next = S_DONE;
        else                                              state_next = S_MODN;
      end
      S_MODN: begin
        // The post-subtract value is checked in the same cycle to save an iteration
        if (n_bad) begin
          map_err_next = 1'b1;
          state_next   = S_DONE;
        end else if (sn_reg < n_ext) begin
          idx_next   = sn_reg[6:0];
          state_next = S_SCAN;
        end else if (sn_sub < n_ext) begin
          idx_next   = sn_sub[6:0];
          state_next = S_SCAN;
        end else if (sub_cnt_reg == 4'(MAXSUB - 1)) begin
          map_err_next = 1'b1;
          state_next   = S_DONE;
        end else begin
          sn_next      = sn_sub;
          sub_cnt_next = sub_cnt_reg + 4'd1;
        end
      end
      S_SCAN: begin
        if (scan_used && (scan_cnt_reg == idx_reg)) begin
          res_ch_next = scan_ch;
          state_next  = S_DONE;
        end else begin
          if (scan_used) scan_cnt_next = scan_cnt_reg + 7'd1;
          if (scan_k_reg == 7'(NCH - 1)) begin
            map_err_next = 1'b1;
            state_next   = S_DONE;
          end else begin
            scan_k_next = scan_k_reg + 7'd1;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control-word capture and the fixed ADD/PERM/SUM pipeline registers
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      x_reg <= '0; a_reg <= '0; c_reg <= '0; y1_reg <= 1'b0; y2_reg <= '0;
      b_reg <= '0; d_reg <= '0; e_reg <= '0; f_reg <= '0; fp_reg <= '0;
      afh_mode_reg <= 1'b0; afh_n_reg <= '0;
      z_reg <= '0; zp_reg <= '0; ch_basic_reg <= '0;
    end else begin
      if (state_reg == S_IDLE && start_p) begin
        x_reg <= X; a_reg <= A; c_reg <= C; y1_reg <= Y1; y2_reg <= Y2;
        b_reg <= B; d_reg <= D; e_reg <= E; f_reg <= F; fp_reg <= Fprime;
        afh_mode_reg <= regi_AFH_mode; afh_n_reg <= regi_AFH_N;
      end
      if (state_reg == S_ADD)  z_reg        <= z_c;
      if (state_reg == S_PERM) zp_reg       <= permute(z_reg, perm_p);
      if (state_reg == S_SUM)  ch_basic_reg <= ch_c;
    end
  end

  // Iteration state registers
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      sn_reg <= '0; sub_cnt_reg <= '0; idx_reg <= '0; scan_k_reg <= '0;
      scan_cnt_reg <= '0; res_ch_reg <= '0; map_err_reg <= 1'b0;
    end else begin
      sn_reg <= sn_next; sub_cnt_reg <= sub_cnt_next; idx_reg <= idx_next;
      scan_k_reg <= scan_k_next; scan_cnt_reg <= scan_cnt_next;
      res_ch_reg <= res_ch_next; map_err_reg <= map_err_next;
    end
  end

  // Result publication: chan_idx updates with the valid pulse and holds
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      chan_idx_reg <= '0;
      chan_vld_reg <= 1'b0;
    end else begin
      chan_vld_reg <= (state_reg == S_DONE);
      if (state_reg == S_DONE) chan_idx_reg <= res_ch_reg;
    end
  end

  assign chan_idx   = chan_idx_reg;
  assign chan_vld_p = chan_vld_reg;
  assign busy       = (state_reg != S_IDLE);
  assign map_err    = map_err_reg;

endmodule
